// File: rtl/sprite_renderer.sv
// sprite_renderer: composites one 128x128 sprite (from an external ROM with a
// registered read) over the background colour, with colour-key transparency.
// The pipeline has three register stages and runs at one pixel per clock with
// no stalls. The sprite position, enable and flip are latched on frame_start,
// so a frame never mixes two positions.
// Optional feature: define SPRITE_FLIP_EN to enable horizontal mirroring via
// flip. Without it the flip input is accepted but not used.

`default_nettype none

module sprite_renderer #(
  parameter int          SPRITE_W  = 128,
  parameter int          SPRITE_H  = 128,
  parameter int          ADDR_W    = 14,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [9:0]        i_hcount,
  input  logic [9:0]        i_vcount,
  input  logic              i_video_on,
  input  logic              i_frame_start,
  input  logic [9:0]        i_sprite_x,
  input  logic [9:0]        i_sprite_y,
  input  logic              i_sprite_en,
  input  logic              i_flip,
  input  logic [11:0]       i_bg_rgb,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [11:0]       i_rom_data,
  output logic [11:0]       o_rgb_out,
  output logic              o_sprite_hit
);

  localparam int          COL_W       = $clog2(SPRITE_W);
  localparam int          ROW_W       = ADDR_W - COL_W;
  localparam logic [10:0] LP_W11      = 11'(SPRITE_W);
  localparam logic [10:0] LP_H11      = 11'(SPRITE_H);
  localparam logic [COL_W-1:0] LP_COL_MAX = COL_W'(SPRITE_W - 1);
  localparam logic [9:0]  LP_VIS_W    = 10'd640;
  localparam logic [9:0]  LP_VIS_H    = 10'd480;

  // Per-frame position/visibility, sampled once at frame_start
  logic [9:0]       r_x_l;
  logic [9:0]       r_y_l;
  logic             r_en_l;

  // Delay line for the per-pixel side information (stage 1 and stage 2)
  logic [11:0]      r_s1_bg;
  logic             r_s1_vid;
  logic             r_s1_box;
  logic [11:0]      r_s2_bg;
  logic             r_s2_vid;
  logic             r_s2_box;

  // Stage 0 combinational terms
  logic [10:0]      w_h11;
  logic [10:0]      w_v11;
  logic [10:0]      w_x11;
  logic [10:0]      w_y11;
  logic             w_in_x;
  logic             w_in_y;
  logic             w_on_screen;
  logic             w_in_box;
  logic [COL_W-1:0] w_col;
  logic [COL_W-1:0] w_col_eff;
  logic [ROW_W-1:0] w_row;

  // Stage 2 combinational result
  logic [11:0]      w_rgb_next;
  logic             w_hit_next;

  // Latch the requested sprite position at the start of each frame
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_x_l  <= '0;
      r_y_l  <= '0;
      r_en_l <= 1'b0;
    end else if (i_frame_start) begin
      r_x_l  <= i_sprite_x;
      r_y_l  <= i_sprite_y;
      r_en_l <= i_sprite_en;
    end
  end

`ifdef SPRITE_FLIP_EN
  logic r_flip_l;

  // Latch the mirror request alongside the position
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_flip_l <= 1'b0;
    end else if (i_frame_start) begin
      r_flip_l <= i_flip;
    end
  end

  // Mirror the column inside the sprite when flip is latched
  always_comb begin
    w_col_eff = w_col;
    if (r_flip_l) begin
      w_col_eff = LP_COL_MAX - w_col;
    end
  end
`else
  logic w_unused_flip;
  assign w_unused_flip = i_flip;

  // No mirroring in this build; column passes straight through
  always_comb begin
    w_col_eff = w_col;
  end
`endif

  // Stage 0: box test in 11 bits so x+W / y+H never wrap past 1023
  always_comb begin
    w_h11       = {1'b0, i_hcount};
    w_v11       = {1'b0, i_vcount};
    w_x11       = {1'b0, r_x_l};
    w_y11       = {1'b0, r_y_l};
    w_in_x      = (w_h11 >= w_x11) && (w_h11 < (w_x11 + LP_W11));
    w_in_y      = (w_v11 >= w_y11) && (w_v11 < (w_y11 + LP_H11));
    // A sprite anchored outside the visible area is never drawn, even if
    // video_on were to be asserted outside 640x480.
    w_on_screen = (r_x_l < LP_VIS_W) && (r_y_l < LP_VIS_H);
    w_in_box    = r_en_l & i_video_on & w_in_x & w_in_y & w_on_screen;
    w_col       = COL_W'(i_hcount - r_x_l);
    w_row       = ROW_W'(i_vcount - r_y_l);
  end

  // Stage 0: drive the ROM address; hold it when outside the box
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rom_addr <= '0;
    end else if (w_in_box) begin
      o_rom_addr <= {w_row, w_col_eff};
    end
  end

  // Stages 0-1: carry background, visibility and box flag alongside the ROM read
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1_bg  <= '0;
      r_s1_vid <= 1'b0;
      r_s1_box <= 1'b0;
      r_s2_bg  <= '0;
      r_s2_vid <= 1'b0;
      r_s2_box <= 1'b0;
    end else begin
      r_s1_bg  <= i_bg_rgb;
      r_s1_vid <= i_video_on;
      r_s1_box <= w_in_box;
      r_s2_bg  <= r_s1_bg;
      r_s2_vid <= r_s1_vid;
      r_s2_box <= r_s1_box;
    end
  end

  // Stage 2: blank outside video, key-colour pixels fall through to background
  always_comb begin
    w_rgb_next = r_s2_bg;
    w_hit_next = 1'b0;
    if (!r_s2_vid) begin
      w_rgb_next = '0;
    end else if (r_s2_box && (i_rom_data != KEY_COLOR)) begin
      w_rgb_next = i_rom_data;
      w_hit_next = 1'b1;
    end
  end

  // Stage 2: output register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rgb_out    <= '0;
      o_sprite_hit <= 1'b0;
    end else begin
      o_rgb_out    <= w_rgb_next;
      o_sprite_hit <= w_hit_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with a registered-read ROM model whose
// data is a simple function of the address, plus one programmable key address.
`timescale 1ns/1ps

module tb_sprite_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        video_on;
  logic        frame_start;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        sprite_en;
  logic        flip;
  logic [11:0] bg_rgb;
  logic [13:0] rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic [11:0] rgb_out;
  logic        sprite_hit;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [13:0] key_addr = 14'h3FFF;

  int a;
  int rgb;
  int hit;

  sprite_renderer dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_hcount     (hcount),
    .i_vcount     (vcount),
    .i_video_on   (video_on),
    .i_frame_start(frame_start),
    .i_sprite_x   (sprite_x),
    .i_sprite_y   (sprite_y),
    .i_sprite_en  (sprite_en),
    .i_flip       (flip),
    .i_bg_rgb     (bg_rgb),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_rgb_out    (rgb_out),
    .o_sprite_hit (sprite_hit)
  );

  always #5 clk = ~clk;

  function automatic int rom_fn(input int addr);
    return (addr + 'h123) & 'hFFF;
  endfunction

  // ROM model: one-cycle registered read
  always @(posedge clk) begin
    if (rom_addr == key_addr) rom_data <= 12'hF0F;
    else                      rom_data <= 12'(rom_fn(int'(rom_addr)));
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int x, input int y, input int en, input int fl);
    sprite_x    = x[9:0];
    sprite_y    = y[9:0];
    sprite_en   = en[0];
    flip        = fl[0];
    frame_start = 1'b1;
    video_on    = 1'b0;
    hcount      = 10'd700;
    vcount      = 10'd490;
    tick();
    frame_start = 1'b0;
  endtask

  // One pixel, then two blanked pixels; returns the address seen after the
  // sampling edge and the output two edges later.
  task automatic run_px(input int h, input int v, input int vid, input int bg,
                        output int ao, output int rgbo, output int hito);
    hcount   = h[9:0];
    vcount   = v[9:0];
    video_on = vid[0];
    bg_rgb   = bg[11:0];
    tick();
    frame_start = 1'b0;
    ao = int'(rom_addr);
    video_on = 1'b0;
    hcount   = 10'd799;
    tick();
    tick();
    rgbo = int'(rgb_out);
    hito = int'(sprite_hit);
  endtask

  initial begin
    reset = 1'b1; hcount = '0; vcount = '0; video_on = 1'b1; frame_start = 1'b0;
    sprite_x = 10'd5; sprite_y = 10'd5; sprite_en = 1'b1; flip = 1'b0; bg_rgb = 12'hABC;
    repeat (3) tick();
    check("rst_addr", int'(rom_addr), 0);
    check("rst_rgb",  int'(rgb_out), 0);
    check("rst_hit",  int'(sprite_hit), 0);
    reset = 1'b0;

    // Basic scan at x=100,y=50
    set_pos(100, 50, 1, 0);
    run_px(100, 50, 1, 'h00A, a, rgb, hit);
    check("left_addr", a, 0);   check("left_rgb", rgb, rom_fn(0));   check("left_hit", hit, 1);
    run_px(227, 50, 1, 'h00A, a, rgb, hit);
    check("right_addr", a, 127); check("right_rgb", rgb, rom_fn(127)); check("right_hit", hit, 1);
    run_px(228, 50, 1, 'h00A, a, rgb, hit);
    check("past_addr_hold", a, 127); check("past_rgb", rgb, 'h00A); check("past_hit", hit, 0);
    run_px(99, 50, 1, 'h00B, a, rgb, hit);
    check("before_rgb", rgb, 'h00B); check("before_hit", hit, 0);
    run_px(105, 51, 1, 'h00A, a, rgb, hit);
    check("r1_addr", a, 133); check("r1_rgb", rgb, rom_fn(133)); check("r1_hit", hit, 1);
    run_px(100, 49, 1, 'h00C, a, rgb, hit);
    check("above_rgb", rgb, 'h00C); check("above_hit", hit, 0);
    run_px(100, 177, 1, 'h00A, a, rgb, hit);
    check("bottom_addr", a, 16256); check("bottom_rgb", rgb, rom_fn(16256)); check("bottom_hit", hit, 1);
    run_px(100, 178, 1, 'h00D, a, rgb, hit);
    check("below_rgb", rgb, 'h00D); check("below_hit", hit, 0);

    // Colour key and video_on=0 inside the box
    key_addr = 14'd133;
    run_px(105, 51, 1, 'h00A, a, rgb, hit);
    check("key_rgb", rgb, 'h00A); check("key_hit", hit, 0);
    run_px(106, 51, 0, 'h00A, a, rgb, hit);
    check("blank_addr_hold", a, 133); check("blank_rgb", rgb, 0); check("blank_hit", hit, 0);
    key_addr = 14'h3FFF;

    // Back-to-back pixels: output trails input by exactly two edges
    for (int i = 0; i < 6; i++) begin
      hcount   = 10'(110 + i);
      vcount   = 10'd52;
      video_on = (i < 4);
      bg_rgb   = 12'h00A;
      tick();
      if (i >= 2) begin
        check("stream_rgb", int'(rgb_out), rom_fn(256 + 10 + i - 2));
        check("stream_hit", int'(sprite_hit), 1);
      end
    end

    // Mid-frame change without frame_start is ignored
    sprite_x = 10'd300;
    run_px(100, 50, 1, 'h00A, a, rgb, hit);
    check("nolatch_addr", a, 0); check("nolatch_hit", hit, 1);
    run_px(300, 50, 1, 'h00A, a, rgb, hit);
    check("nolatch_new_hit", hit, 0);
    set_pos(300, 50, 1, 0);
    run_px(300, 50, 1, 'h00A, a, rgb, hit);
    check("latch_addr", a, 0); check("latch_hit", hit, 1);
    run_px(100, 50, 1, 'h00E, a, rgb, hit);
    check("latch_old_rgb", rgb, 'h00E); check("latch_old_hit", hit, 0);

    // frame_start coincident with a visible pixel: that pixel uses the old x
    sprite_x = 10'd400; frame_start = 1'b1;
    run_px(305, 50, 1, 'h00A, a, rgb, hit);
    check("coin_addr", a, 5); check("coin_hit", hit, 1);
    run_px(410, 50, 1, 'h00A, a, rgb, hit);
    check("coin_new_addr", a, 10); check("coin_new_hit", hit, 1);
    run_px(310, 50, 1, 'h00A, a, rgb, hit);
    check("coin_old_gone", hit, 0);

    // Right-edge clipping at x=600, no wrap to column 0
    set_pos(600, 50, 1, 0);
    run_px(600, 50, 1, 'h00A, a, rgb, hit);
    check("clip_l_addr", a, 0); check("clip_l_hit", hit, 1);
    run_px(639, 50, 1, 'h00A, a, rgb, hit);
    check("clip_r_addr", a, 39); check("clip_r_rgb", rgb, rom_fn(39)); check("clip_r_hit", hit, 1);
    run_px(640, 50, 0, 'h00A, a, rgb, hit);
    check("clip_off_rgb", rgb, 0); check("clip_off_hit", hit, 0);
    run_px(0, 50, 1, 'h005, a, rgb, hit);
    check("nowrap0_addr", a, 39); check("nowrap0_rgb", rgb, 'h005); check("nowrap0_hit", hit, 0);
    run_px(87, 50, 1, 'h006, a, rgb, hit);
    check("nowrap87_rgb", rgb, 'h006); check("nowrap87_hit", hit, 0);

    // Sprite anchored off screen is never hit
    set_pos(650, 50, 1, 0);
    run_px(660, 50, 1, 'h007, a, rgb, hit);
    check("offx_rgb", rgb, 'h007); check("offx_hit", hit, 0);
    set_pos(100, 480, 1, 0);
    run_px(100, 480, 1, 'h008, a, rgb, hit);
    check("offy_rgb", rgb, 'h008); check("offy_hit", hit, 0);

    // Disabled sprite
    set_pos(100, 50, 0, 0);
    run_px(100, 50, 1, 'h009, a, rgb, hit);
    check("dis_rgb", rgb, 'h009); check("dis_hit", hit, 0);

    // Flip request
    set_pos(100, 50, 1, 1);
    run_px(100, 50, 1, 'h00A, a, rgb, hit);
`ifdef SPRITE_FLIP_EN
    check("flip_l_addr", a, 127);
`else
    check("flip_l_addr", a, 0);
`endif
    run_px(227, 50, 1, 'h00A, a, rgb, hit);
`ifdef SPRITE_FLIP_EN
    check("flip_r_addr", a, 0);
`else
    check("flip_r_addr", a, 127);
`endif

    // Reset in the middle of a line
    set_pos(100, 50, 1, 0);
    hcount = 10'd120; vcount = 10'd60; video_on = 1'b1; bg_rgb = 12'h00A;
    tick();
    hcount = 10'd121; tick();
    hcount = 10'd122; tick();
    check("hot_rgb", int'(rgb_out), rom_fn(10 * 128 + 20));
    check("hot_hit", int'(sprite_hit), 1);
    #2 reset = 1'b1;
    #1;
    check("mrst_rgb",  int'(rgb_out), 0);
    check("mrst_hit",  int'(sprite_hit), 0);
    check("mrst_addr", int'(rom_addr), 0);
    @(posedge clk);
    #1;
    reset = 1'b0; hcount = 10'd123; vcount = 10'd60; video_on = 1'b1; bg_rgb = 12'h0F0;
    tick();
    check("post1_rgb", int'(rgb_out), 0);
    tick();
    check("post2_rgb", int'(rgb_out), 0);
    tick();
    check("post3_rgb", int'(rgb_out), 'h0F0);
    check("post3_hit", int'(sprite_hit), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
